fifo_sel_arb: RTL and testbench
===============================

Name: fifo_sel_arb

Overview:
Parametrised successor of the FIFO-select calculator. Arbitrates PORT_NUM FIFO request bits, locks the winning FIFO until the consumer releases it or the request drops, and outputs the 8-bit select code 128+index (0 = none). Adds a selectable fixed-priority or round-robin mode, a release handshake, a one-hot grant vector and a busy flag. Sits between the per-port FIFO status logic and the downstream FIFO read mux.

Parameters:
PORT_NUM, 8, number of request bits; legal range 1..128.
RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
TIMEOUT_CYC, 255, lock timeout in cycles; used only with FIFO_SEL_TIMEOUT_EN; legal range 1..65535.

Ports:
glb_clk  input  1  single clock, rising edge.
glb_areset  input  1  asynchronous active-high reset.
fifo_sel_bits  input  PORT_NUM  per-FIFO request; level, bit i = FIFO i wants service.
fifo_sel_done  input  1  one-cycle release pulse from consumer; ignored in IDLE.
fifo_sel_res_final  output  8  select code: 8'd128+index while locked, 8'd0 otherwise.
fifo_sel_onehot  output  PORT_NUM  one-hot of the locked FIFO; all zero otherwise.
fifo_sel_busy  output  1  high while in LOCK.
fifo_sel_timeout  output  1  one-cycle pulse on forced release; tied 0 without the optional feature.

Behaviour:
- Reset: async active-high. State=IDLE; all outputs 0; RR pointer=0; timeout counter=0. Reset mid-LOCK drops the grant immediately, with no done required.
- All outputs are registered; none depend combinationally on inputs.
- States: IDLE and LOCK.
- IDLE:
  - If fifo_sel_bits != 0, pick a winner and go to LOCK.
  - On that edge, load code = 128+winner, onehot = 1<<winner, busy=1.
  - Latency is one cycle from request seen to grant visible.
- Winner selection, fixed mode: lowest set index.
- Winner selection, RR mode:
  - First set index at or above the pointer, wrapping to 0.
  - On grant, pointer <= winner+1, wrapping PORT_NUM-1 -> 0.
- LOCK holds the code stable until either:
  - fifo_sel_done=1, or
  - fifo_sel_bits[locked index]=0.
  Then go to IDLE; outputs are 0 after that edge.
- Done and request drop in the same cycle: a single release.
- After any release, at least one IDLE cycle passes before the next grant (no back-to-back grants). This matches the none-to-some capture rule of the previous generation.
- Changes on other request bits during LOCK are ignored. They are evaluated in the next IDLE cycle.
- Index width is clog2(PORT_NUM), minimum 1. The code is index zero-extended to 7 bits with bit 7 as valid. PORT_NUM=1 gives code 128 only.

Optional Feature:
FIFO_SEL_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entering LOCK and increments each LOCK cycle.
  - When count reaches TIMEOUT_CYC-1 with no release, force IDLE.
  - fifo_sel_timeout pulses for one cycle, aligned with outputs going to 0.
  - In RR mode the pointer is already past the stalled FIFO.
  - A normal release in the same cycle takes priority; no timeout pulse.
- Undefined: no counter; fifo_sel_timeout tied 0; LOCK can persist indefinitely.

Decomposition:
- Shared package fifo_sel_pkg holds:
  - state encoding (IDLE=1'b0, LOCK=1'b1)
  - SEL_VALID_BIT=7
  - NON_FIFO_CHOOSE=8'd0
  - function to form code from index
- One natural sub-module: fifo_sel_prio_pick.
  - Combinational rotate-and-priority-encode.
  - Inputs: request vector, pointer, mode.
  - Outputs: index and any-valid.

Test Plan:
- Fixed mode, PORT_NUM=8, bits=8'b0010_1000 -> one cycle later code=8'd131, onehot=8'h08, busy=1; stays until done pulse; after the done edge code=0, busy=0.
- RR mode, bits held at 8'hFF with done pulsed every lock -> successive codes 128,129,...,135,128, with exactly one idle cycle between grants.
- Locked on index 2, bit 2 cleared while bit 5 set -> release the next edge; idle one cycle; then code=8'd133.
- Done and request drop in the same cycle; done pulsed in IDLE -> single release; no spurious grant or state change.
- glb_areset asserted mid-LOCK (code=8'd134) -> all outputs 0 asynchronously; pointer 0; after deassert with bits=8'h41, fixed mode grants 128, and RR mode also grants 128.
- With FIFO_SEL_TIMEOUT_EN and TIMEOUT_CYC=4, lock with no done -> after 4 LOCK cycles fifo_sel_timeout=1 for one cycle and code=0. Done on the final cycle -> no timeout pulse.

Source files
------------

// File: rtl/fifo_sel_pkg.sv
// Shared definitions for the FIFO-select arbiter: state encoding, select-code
// layout and helpers.
package fifo_sel_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Bit 7 of the select code marks a valid selection; the low 7 bits carry the index.
    localparam int         SEL_VALID_BIT   = 7;
    localparam logic [7:0] NON_FIFO_CHOOSE = 8'd0;

    // Index width for a given port count, never narrower than one bit.
    function automatic int idx_width(input int port_num);
        return (port_num > 1) ? $clog2(port_num) : 1;
    endfunction

    // Select code for a locked FIFO: zero-extended index with the valid bit set.
    function automatic logic [7:0] make_code(input logic [6:0] idx);
        logic [7:0] code;
        code                = {1'b0, idx};
        code[SEL_VALID_BIT] = 1'b1;
        return code;
    endfunction

endpackage

// File: rtl/fifo_sel_prio_pick.sv
// Rotating priority encoder: returns the first set request at or above the
// start pointer (wrapping), or the lowest set request when rr_mode is low.
module fifo_sel_prio_pick #(
    parameter int PORT_NUM = 8,
    parameter int IDX_W    = 3
) (
    input  logic [PORT_NUM-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    input  logic                rr_mode,
    output logic [IDX_W-1:0]    idx,
    output logic                valid
);

    // Scan offsets from farthest to nearest so the nearest set request wins last.
    always_comb begin
        int base;
        int cand;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        idx   = '0;
        valid = |req;
        base  = rr_mode ? int'(ptr) : 0;
        for (int k = PORT_NUM - 1; k >= 0; k--) begin
            cand = base + k;
            if (cand >= PORT_NUM) begin
                cand = cand - PORT_NUM;
            end
            if (req[cand]) begin
                idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_sel_arb.sv
// FIFO-select arbiter: grants one requesting FIFO, holds the grant until the
// consumer releases it or the request drops, and presents the select code
// 128+index, a one-hot grant and a busy flag. All outputs are registered.
// Optional lock timeout enabled by defining FIFO_SEL_TIMEOUT_EN.
module fifo_sel_arb
    import fifo_sel_pkg::*;
#(
    parameter int PORT_NUM    = 8,
    parameter int RR_MODE     = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                glb_clk,
    input  logic                glb_areset,
    input  logic [PORT_NUM-1:0] fifo_sel_bits,
    input  logic                fifo_sel_done,
    output logic [7:0]          fifo_sel_res_final,
    output logic [PORT_NUM-1:0] fifo_sel_onehot,
    output logic                fifo_sel_busy,
    output logic                fifo_sel_timeout
);

    localparam int IDX_W = idx_width(PORT_NUM);

    state_t           state;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_next;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             release_req;
    logic             timeout_fire;

    fifo_sel_prio_pick #(
        .PORT_NUM (PORT_NUM),
        .IDX_W    (IDX_W)
    ) u_prio_pick (
        .req     (fifo_sel_bits),
        .ptr     (rr_ptr),
        .rr_mode (RR_MODE != 0),
        .idx     (win_idx),
        .valid   (win_valid)
    );

    // Release when the consumer is done or the locked FIFO withdraws its request.
    assign release_req = fifo_sel_done || !fifo_sel_bits[lock_idx];

    // Pointer moves one past the winner so the stalled/served FIFO goes last next time.
    assign rr_next = (win_idx == IDX_W'(PORT_NUM - 1)) ? '0 : win_idx + IDX_W'(1);

`ifdef FIFO_SEL_TIMEOUT_EN
    logic [15:0] to_cnt;

    // A normal release in the same cycle takes priority over the timeout.
    assign timeout_fire = (state == LOCK) && !release_req &&
                          (to_cnt == 16'(TIMEOUT_CYC - 1));

    // Count LOCK cycles (held at zero while idle) and pulse on a forced release.
    always_ff @(posedge glb_clk or posedge glb_areset) begin
        if (glb_areset) begin
            to_cnt           <= '0;
            fifo_sel_timeout <= 1'b0;
        end else begin
            fifo_sel_timeout <= timeout_fire;
            if (state == IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end
        end
    end
`else
    assign timeout_fire     = 1'b0;
    assign fifo_sel_timeout = 1'b0;
`endif

    // Grant/lock state machine with registered select outputs.
    always_ff @(posedge glb_clk or posedge glb_areset) begin
        if (glb_areset) begin
            state              <= IDLE;
            lock_idx           <= '0;
            rr_ptr             <= '0;
            fifo_sel_res_final <= NON_FIFO_CHOOSE;
            fifo_sel_onehot    <= '0;
            fifo_sel_busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state)
                IDLE: begin
                    if (win_valid) begin
                        state              <= LOCK;
                        lock_idx           <= win_idx;
                        fifo_sel_res_final <= make_code(7'(win_idx));
                        fifo_sel_onehot    <= PORT_NUM'(1) << win_idx;
                        fifo_sel_busy      <= 1'b1;
                        if (RR_MODE != 0) begin
                            rr_ptr <= rr_next;
                        end
                    end
                end
                LOCK: begin
                    if (release_req || timeout_fire) begin
                        state              <= IDLE;
                        fifo_sel_res_final <= NON_FIFO_CHOOSE;
                        fifo_sel_onehot    <= '0;
                        fifo_sel_busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_sel_arb.sv
// Self-checking bench for fifo_sel_arb: one fixed-priority and one
// round-robin instance (PORT_NUM=8, TIMEOUT_CYC=4), a vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_fifo_sel_arb;

    localparam int N  = 8;
    localparam int TO = 4;

    logic         glb_clk;
    logic         glb_areset;
    logic [N-1:0] fix_bits, rr_bits;
    logic         fix_done, rr_done;
    logic [7:0]   fix_code, rr_code;
    logic [N-1:0] fix_oh, rr_oh;
    logic         fix_busy, rr_busy;
    logic         fix_to, rr_to;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_sel_arb #(.PORT_NUM(N), .RR_MODE(0), .TIMEOUT_CYC(TO)) u_fix (
        .glb_clk            (glb_clk),
        .glb_areset         (glb_areset),
        .fifo_sel_bits      (fix_bits),
        .fifo_sel_done      (fix_done),
        .fifo_sel_res_final (fix_code),
        .fifo_sel_onehot    (fix_oh),
        .fifo_sel_busy      (fix_busy),
        .fifo_sel_timeout   (fix_to)
    );

    fifo_sel_arb #(.PORT_NUM(N), .RR_MODE(1), .TIMEOUT_CYC(TO)) u_rr (
        .glb_clk            (glb_clk),
        .glb_areset         (glb_areset),
        .fifo_sel_bits      (rr_bits),
        .fifo_sel_done      (rr_done),
        .fifo_sel_res_final (rr_code),
        .fifo_sel_onehot    (rr_oh),
        .fifo_sel_busy      (rr_busy),
        .fifo_sel_timeout   (rr_to)
    );

    initial glb_clk = 1'b0;
    always #5 glb_clk = ~glb_clk;

    // Reference model: who holds the grant, the round-robin start, lock age.
    typedef struct packed {
        logic        busy;
        logic [2:0]  idx;
        logic [2:0]  ptr;
        logic [15:0] cnt;
        logic        to;
    } mdl_t;

    localparam mdl_t MDL_RST = '0;

    mdl_t m_fix, m_rr;

    function automatic mdl_t mdl_next(input mdl_t m, input logic [7:0] bits,
                                      input logic done, input logic rr);
        mdl_t n;
        int   start;
        bit   found;
        n     = m;
        n.to  = 1'b0;
        found = 1'b0;
        if (!m.busy) begin
            start = rr ? int'(m.ptr) : 0;
            for (int k = 0; k < N; k++) begin
                if (!found && bits[(start + k) % N]) begin
                    found  = 1'b1;
                    n.busy = 1'b1;
                    n.idx  = 3'((start + k) % N);
                    n.cnt  = '0;
                    if (rr) n.ptr = 3'((start + k + 1) % N);
                end
            end
        end else if (done || !bits[m.idx]) begin
            n.busy = 1'b0;
        end else begin
`ifdef FIFO_SEL_TIMEOUT_EN
            if (int'(m.cnt) == TO - 1) begin
                n.busy = 1'b0;
                n.to   = 1'b1;
            end else begin
                n.cnt = m.cnt + 16'd1;
            end
`endif
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input mdl_t m, input logic [7:0] code,
                       input logic [7:0] oh, input logic busy, input logic to);
        check({tag, ".code"},    32'(code), m.busy ? 32'(128 + int'(m.idx)) : 32'd0);
        check({tag, ".onehot"},  32'(oh),   m.busy ? (32'd1 << m.idx) : 32'd0);
        check({tag, ".busy"},    32'(busy), 32'(m.busy));
        check({tag, ".timeout"}, 32'(to),   32'(m.to));
    endtask

    // One clock: drive at the falling edge, advance the model at the rising
    // edge, compare both instances shortly after.
    task automatic step(input logic [7:0] fb, input logic fd,
                        input logic [7:0] rb, input logic rd);
        @(negedge glb_clk);
        fix_bits = fb;
        fix_done = fd;
        rr_bits  = rb;
        rr_done  = rd;
        @(posedge glb_clk);
        m_fix = mdl_next(m_fix, fb, fd, 1'b0);
        m_rr  = mdl_next(m_rr,  rb, rd, 1'b1);
        #1;
        cmp("fix", m_fix, fix_code, fix_oh, fix_busy, fix_to);
        cmp("rr",  m_rr,  rr_code,  rr_oh,  rr_busy,  rr_to);
    endtask

    typedef struct {
        logic [7:0] bits;
        logic       done;
        logic [7:0] code;
        logic [7:0] onehot;
        logic       busy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [7:0] rb, fb;

        vecs[0]  = '{8'h28, 1'b0, 8'd131, 8'h08, 1'b1}; // lowest of bits 3,5
        vecs[1]  = '{8'h28, 1'b0, 8'd131, 8'h08, 1'b1}; // held
        vecs[2]  = '{8'h28, 1'b1, 8'd0,   8'h00, 1'b0}; // done releases
        vecs[3]  = '{8'h28, 1'b0, 8'd131, 8'h08, 1'b1}; // regrant after one idle
        vecs[4]  = '{8'h20, 1'b0, 8'd0,   8'h00, 1'b0}; // locked bit drops
        vecs[5]  = '{8'h20, 1'b0, 8'd133, 8'h20, 1'b1};
        vecs[6]  = '{8'h24, 1'b0, 8'd133, 8'h20, 1'b1}; // new lower bit ignored
        vecs[7]  = '{8'h04, 1'b1, 8'd0,   8'h00, 1'b0}; // done + drop together
        vecs[8]  = '{8'h00, 1'b1, 8'd0,   8'h00, 1'b0}; // done in idle ignored
        vecs[9]  = '{8'h00, 1'b0, 8'd0,   8'h00, 1'b0};
        vecs[10] = '{8'h04, 1'b0, 8'd130, 8'h04, 1'b1};
        vecs[11] = '{8'h24, 1'b0, 8'd130, 8'h04, 1'b1};
        vecs[12] = '{8'h20, 1'b0, 8'd0,   8'h00, 1'b0}; // bit 2 drops
        vecs[13] = '{8'h20, 1'b0, 8'd133, 8'h20, 1'b1}; // bit 5 after idle

        glb_areset = 1'b1;
        fix_bits   = '0;
        fix_done   = 1'b0;
        rr_bits    = '0;
        rr_done    = 1'b0;
        m_fix      = MDL_RST;
        m_rr       = MDL_RST;
        #12;
        cmp("reset_fix", m_fix, fix_code, fix_oh, fix_busy, fix_to);
        cmp("reset_rr",  m_rr,  rr_code,  rr_oh,  rr_busy,  rr_to);
        @(negedge glb_clk);
        glb_areset = 1'b0;

        // Round-robin walk over all ports with one idle cycle between grants.
        for (int g = 0; g < 9; g++) begin
            step(8'h00, 1'b0, 8'hFF, 1'b0);
            check("rr_walk.code", 32'(rr_code), 32'(128 + (g % N)));
            step(8'h00, 1'b0, 8'hFF, 1'b1);
            check("rr_walk.idle", 32'(rr_code), 32'd0);
        end
        step(8'h00, 1'b0, 8'h00, 1'b0);

        // Fixed-priority vector table.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].bits, vecs[i].done, 8'h00, 1'b0);
            check($sformatf("vec%0d.code", i),   32'(fix_code), 32'(vecs[i].code));
            check($sformatf("vec%0d.onehot", i), 32'(fix_oh),   32'(vecs[i].onehot));
            check($sformatf("vec%0d.busy", i),   32'(fix_busy), 32'(vecs[i].busy));
        end
        step(8'h00, 1'b0, 8'h00, 1'b0);
        step(8'h00, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a lock.
        step(8'h40, 1'b0, 8'h08, 1'b0);
        check("pre_rst.fix", 32'(fix_code), 32'd134);
        check("pre_rst.rr",  32'(rr_code),  32'd131);
        @(posedge glb_clk);
        #3;
        glb_areset = 1'b1;
        fix_bits   = '0;
        rr_bits    = '0;
        #1;
        check("async_rst.fix_code", 32'(fix_code), 32'd0);
        check("async_rst.fix_oh",   32'(fix_oh),   32'd0);
        check("async_rst.fix_busy", 32'(fix_busy), 32'd0);
        check("async_rst.rr_code",  32'(rr_code),  32'd0);
        check("async_rst.rr_busy",  32'(rr_busy),  32'd0);
        m_fix = MDL_RST;
        m_rr  = MDL_RST;
        @(negedge glb_clk);
        glb_areset = 1'b0;
        step(8'h41, 1'b0, 8'h41, 1'b0);
        check("post_rst.fix", 32'(fix_code), 32'd128);
        check("post_rst.rr",  32'(rr_code),  32'd128);
        step(8'h41, 1'b1, 8'h41, 1'b1);
        step(8'h00, 1'b0, 8'h00, 1'b0);

`ifdef FIFO_SEL_TIMEOUT_EN
        // Stalled lock: four LOCK cycles, then a forced release with a pulse.
        for (int c = 0; c < TO; c++) begin
            step(8'h01, 1'b0, 8'h00, 1'b0);
            check("to_lock.busy", 32'(fix_busy), 32'd1);
            check("to_lock.pulse", 32'(fix_to), 32'd0);
        end
        step(8'h01, 1'b0, 8'h00, 1'b0);
        check("to_fire.pulse", 32'(fix_to),   32'd1);
        check("to_fire.code",  32'(fix_code), 32'd0);
        step(8'h01, 1'b0, 8'h00, 1'b0);
        check("to_after.pulse", 32'(fix_to),   32'd0);
        check("to_after.code",  32'(fix_code), 32'd128);
        // Done on the final LOCK cycle wins over the timeout.
        for (int c = 1; c < TO; c++) step(8'h01, 1'b0, 8'h00, 1'b0);
        step(8'h01, 1'b1, 8'h00, 1'b0);
        check("to_done.pulse", 32'(fix_to),   32'd0);
        check("to_done.code",  32'(fix_code), 32'd0);
        step(8'h00, 1'b0, 8'h00, 1'b0);
`endif

        // Randomized traffic; requests persist for a while so locks last.
        fb = '0;
        rb = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) fb = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 8'($urandom) | 8'($urandom);
            step(fb, ($urandom_range(0, 5) == 0), rb, ($urandom_range(0, 4) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
